// File: rtl/reg_xfer_sequencer.sv
// Register-file bus master: MOV / LDI / RD over the shared tristate bus.
// Define REG_XFER_SWAP_EN to build op 11 as SWAP; otherwise op 11 reports cmd_err.
module reg_xfer_sequencer #(
  parameter int DATA_W = 8,
  parameter int SEL_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [SEL_W-1:0]  cmd_src,
  input  logic [SEL_W-1:0]  cmd_dst,
  input  logic [DATA_W-1:0] cmd_imm,
  output logic [SEL_W-1:0]  regSel,
  output logic              Rin,
  output logic              Rout,
  inout  wire  [DATA_W-1:0] bus,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              cmd_err
);

  localparam logic [1:0] OP_MOV  = 2'b00;
  localparam logic [1:0] OP_LDI  = 2'b01;
  localparam logic [1:0] OP_RD   = 2'b10;
  localparam logic [1:0] OP_SWAP = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    SRC_OUT,
    DST_IN,
    IMM_IN,
    RD_OUT,
    ERR
`ifdef REG_XFER_SWAP_EN
    , DST_OUT
    , SRC_IN
`endif
  } state_t;

  state_t state_q, state_d;

  logic [SEL_W-1:0]  src_q, dst_q;
  logic [DATA_W-1:0] imm_q, tmp0;
  logic [DATA_W-1:0] drv;
  logic              bus_oe;
`ifdef REG_XFER_SWAP_EN
  logic              swap_q;
  logic [DATA_W-1:0] tmp1;
`endif

  assign cmd_ready = (state_q == IDLE);
  assign bus       = bus_oe ? drv : 'z;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          unique case (cmd_op)
            OP_MOV:  state_d = SRC_OUT;
            OP_LDI:  state_d = IMM_IN;
            OP_RD:   state_d = RD_OUT;
            OP_SWAP: begin
`ifdef REG_XFER_SWAP_EN
              state_d = SRC_OUT;
`else
              state_d = ERR;
`endif
            end
          endcase
        end
      end
`ifdef REG_XFER_SWAP_EN
      SRC_OUT: state_d = swap_q ? DST_OUT : DST_IN;
      DST_IN:  state_d = swap_q ? SRC_IN : IDLE;
      DST_OUT: state_d = DST_IN;
      SRC_IN:  state_d = IDLE;
`else
      SRC_OUT: state_d = DST_IN;
      DST_IN:  state_d = IDLE;
`endif
      IMM_IN:  state_d = IDLE;
      RD_OUT:  state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Rout states never drive the bus; every Rin state drives it.
  always_comb begin
    regSel = '0;
    Rin    = 1'b0;
    Rout   = 1'b0;
    bus_oe = 1'b0;
    drv    = '0;
    unique case (1'b1)
      (state_q == SRC_OUT),
      (state_q == RD_OUT): begin
        regSel = src_q;
        Rout   = 1'b1;
      end
      (state_q == DST_IN): begin
        regSel = dst_q;
        Rin    = 1'b1;
        bus_oe = 1'b1;
        drv    = tmp0;
      end
      (state_q == IMM_IN): begin
        regSel = dst_q;
        Rin    = 1'b1;
        bus_oe = 1'b1;
        drv    = imm_q;
      end
`ifdef REG_XFER_SWAP_EN
      (state_q == DST_OUT): begin
        regSel = dst_q;
        Rout   = 1'b1;
      end
      (state_q == SRC_IN): begin
        regSel = src_q;
        Rin    = 1'b1;
        bus_oe = 1'b1;
        drv    = tmp1;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      src_q    <= '0;
      dst_q    <= '0;
      imm_q    <= '0;
      tmp0     <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      cmd_err  <= 1'b0;
`ifdef REG_XFER_SWAP_EN
      swap_q   <= 1'b0;
      tmp1     <= '0;
`endif
    end else begin
      state_q  <= state_d;
      rd_valid <= (state_q == RD_OUT);
      cmd_err  <= (state_q == ERR);
      if (cmd_valid && cmd_ready) begin
        src_q  <= cmd_src;
        dst_q  <= cmd_dst;
        imm_q  <= cmd_imm;
`ifdef REG_XFER_SWAP_EN
        swap_q <= (cmd_op == OP_SWAP);
`endif
      end
      if (state_q == SRC_OUT) tmp0 <= bus;
      if (state_q == RD_OUT) rd_data <= bus;
`ifdef REG_XFER_SWAP_EN
      if (state_q == DST_OUT) tmp1 <= bus;
`endif
    end
  end

endmodule
